// File: rtl/alu_unit.sv
// EX-stage integer execute block: decodes ALUOp/Funct3/Funct7 into an aluselect
// code, computes the ALU result and registers result, zero flag and code once.
module alu_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            ALUOp,
    input  logic [2:0]            Funct3,
    input  logic [6:0]            Funct7,
    input  logic [DATA_WIDTH-1:0] input0,
    input  logic [DATA_WIDTH-1:0] input1,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  is_zero,
    output logic [3:0]            aluselect
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_EQ   = 4'd10,
        OP_SGE  = 4'd11,
        OP_SGEU = 4'd12,
        OP_PASS = 4'd13,
        OP_RSV  = 4'd14,
        OP_ILL  = 4'd15
    } alu_sel_t;

    alu_sel_t              sel_d;
    logic                  alt;
    logic [SH_W-1:0]       sh;
    logic                  signed_lt;
    logic                  unsigned_lt;
    logic                  equal;
    logic [DATA_WIDTH-1:0] result;
    logic                  unused_f7;

    // Only Funct7[5] distinguishes SUB/SRA; the other bits carry no meaning here.
    assign alt       = Funct7[5];
    assign unused_f7 = ^{Funct7[6], Funct7[4:0]};

    always_comb begin
        sel_d = OP_ILL;
        case (ALUOp)
            3'b000: sel_d = OP_ADD;
            3'b001: begin
                case (Funct3)
                    3'b000, 3'b001: sel_d = OP_EQ;
                    3'b100:         sel_d = OP_SLT;
                    3'b101:         sel_d = OP_SGE;
                    3'b110:         sel_d = OP_SLTU;
                    3'b111:         sel_d = OP_SGEU;
                    default:        sel_d = OP_ILL;
                endcase
            end
            // I-type shares the R-type table; ADDI has no SUB form, SRAI does.
            3'b010, 3'b011: begin
                case (Funct3)
                    3'b000:  sel_d = (alt && (ALUOp == 3'b010)) ? OP_SUB : OP_ADD;
                    3'b001:  sel_d = OP_SLL;
                    3'b010:  sel_d = OP_SLT;
                    3'b011:  sel_d = OP_SLTU;
                    3'b100:  sel_d = OP_XOR;
                    3'b101:  sel_d = alt ? OP_SRA : OP_SRL;
                    3'b110:  sel_d = OP_OR;
                    default: sel_d = OP_AND;
                endcase
            end
            3'b100:  sel_d = OP_PASS;
            default: sel_d = OP_ILL;
        endcase
    end

    assign sh          = input1[SH_W-1:0];
    assign signed_lt   = $signed(input0) < $signed(input1);
    assign unsigned_lt = input0 < input1;
    assign equal       = input0 == input1;

    always_comb begin
        result = '0;
        case (sel_d)
            OP_ADD:  result = input0 + input1;
            OP_SUB:  result = input0 - input1;
            OP_SLL:  result = input0 << sh;
            OP_SRL:  result = input0 >> sh;
            OP_SRA:  result = $unsigned($signed(input0) >>> sh);
            OP_AND:  result = input0 & input1;
            OP_OR:   result = input0 | input1;
            OP_XOR:  result = input0 ^ input1;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, signed_lt};
            OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, unsigned_lt};
            OP_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, equal};
            OP_SGE:  result = {{(DATA_WIDTH-1){1'b0}}, ~signed_lt};
            OP_SGEU: result = {{(DATA_WIDTH-1){1'b0}}, ~unsigned_lt};
            OP_PASS: result = input1;
            default: result = '0;
        endcase
    end

    // Outputs hold their last valid operation while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            is_zero   <= 1'b1;
            out_valid <= 1'b0;
            aluselect <= 4'hF;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out       <= result;
                is_zero   <= (result == '0);
                aluselect <= sel_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed cases from the datapath's corner values followed by
// randomized traffic checked against an arithmetic reference model.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] input0;
    logic [31:0] input1;
    logic        out_valid;
    logic [31:0] out;
    logic        is_zero;
    logic [3:0]  aluselect;

    int errors = 0;
    int checks = 0;

    bit [31:0] exp_out;
    bit        exp_zero;
    bit        exp_valid;
    bit [3:0]  exp_sel;

    alu_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .input0    (input0),
        .input1    (input1),
        .out_valid (out_valid),
        .out       (out),
        .is_zero   (is_zero),
        .aluselect (aluselect)
    );

    always #5 clk = ~clk;

    // Instruction-level meaning of the control fields, as an operation code.
    function automatic bit [3:0] ref_decode(bit [2:0] op, bit [2:0] f3, bit [6:0] f7);
        bit [3:0] rtab [8] = '{4'd0, 4'd2, 4'd8, 4'd9, 4'd7, 4'd3, 4'd6, 4'd5};
        bit [3:0] btab [8] = '{4'd10, 4'd10, 4'd15, 4'd15, 4'd8, 4'd11, 4'd9, 4'd12};
        bit [3:0] code;
        if (op == 3'd0) return 4'd0;
        if (op == 3'd1) return btab[f3];
        if (op == 3'd4) return 4'd13;
        if (op > 3'd4)  return 4'd15;
        code = rtab[f3];
        if (f3 == 3'd0 && op == 3'd2 && f7[5]) code = 4'd1;
        if (f3 == 3'd5 && f7[5]) code = 4'd4;
        return code;
    endfunction

    // Result computed with wide integer arithmetic rather than bit operators.
    function automatic bit [31:0] ref_compute(bit [3:0] code, bit [31:0] a, bit [31:0] b);
        longint m  = longint'(1) << 32;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= (m / 2)) ? ua - m : ua;
        longint sb = (ub >= (m / 2)) ? ub - m : ub;
        longint p  = longint'(1) << (ub % 32);
        longint r;
        case (code)
            4'd0:    r = (ua + ub) % m;
            4'd1:    r = (ua - ub + m) % m;
            4'd2:    r = (ua * p) % m;
            4'd3:    r = ua / p;
            4'd4:    r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            4'd5:    r = longint'(a & b);
            4'd6:    r = longint'(a | b);
            4'd7:    r = longint'(a ^ b);
            4'd8:    r = (sa < sb) ? 1 : 0;
            4'd9:    r = (ua < ub) ? 1 : 0;
            4'd10:   r = (ua == ub) ? 1 : 0;
            4'd11:   r = (sa >= sb) ? 1 : 0;
            4'd12:   r = (ua >= ub) ? 1 : 0;
            4'd13:   r = ub;
            default: r = 0;
        endcase
        if (r < 0) r = r + m;
        return r[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle, advances the reference state, then compares all outputs.
    task automatic applyStimulus(input bit r, input bit v, input bit [2:0] op, input bit [2:0] f3,
                                 input bit [6:0] f7, input bit [31:0] a, input bit [31:0] b,
                                 input string tag);
        rst      = r;
        in_valid = v;
        ALUOp    = op;
        Funct3   = f3;
        Funct7   = f7;
        input0   = a;
        input1   = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_out   = 32'd0;
            exp_zero  = 1'b1;
            exp_valid = 1'b0;
            exp_sel   = 4'd15;
        end else if (v) begin
            exp_sel   = ref_decode(op, f3, f7);
            exp_out   = ref_compute(exp_sel, a, b);
            exp_zero  = (exp_out == 32'd0);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        checkOutput({tag, ".out"},       out,                exp_out);
        checkOutput({tag, ".is_zero"},   {31'd0, is_zero},   {31'd0, exp_zero});
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        checkOutput({tag, ".aluselect"}, {28'd0, aluselect}, {28'd0, exp_sel});
    endtask

    initial begin
        bit        r_r, r_v;
        bit [2:0]  r_op, r_f3;
        bit [6:0]  r_f7;
        bit [31:0] r_a, r_b;
        bit [31:0] specials [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        exp_out = 0; exp_zero = 1; exp_valid = 0; exp_sel = 15;

        applyStimulus(1, 1, 3'd2, 3'd0, 7'h00, 32'd5, 32'd7, "reset");
        checkOutput("reset_out_const", out, 32'd0);
        checkOutput("reset_sel_const", {28'd0, aluselect}, 32'd15);
        applyStimulus(1, 1, 3'd2, 3'd0, 7'h00, 32'd5, 32'd7, "reset2");

        applyStimulus(0, 1, 3'd2, 3'd0, 7'h00, 32'd5, 32'd7, "add");
        checkOutput("add_const", out, 32'd12);
        applyStimulus(0, 1, 3'd2, 3'd0, 7'h20, 32'd5, 32'd7, "sub");
        checkOutput("sub_const", out, 32'hFFFF_FFFE);
        applyStimulus(0, 1, 3'd2, 3'd0, 7'h20, 32'd3, 32'd3, "sub_zero");
        checkOutput("sub_zero_flag", {31'd0, is_zero}, 32'd1);

        applyStimulus(0, 1, 3'd2, 3'd1, 7'h00, 32'h8000_0000, 32'h24, "sll");
        checkOutput("sll_const", out, 32'd0);
        applyStimulus(0, 1, 3'd2, 3'd5, 7'h00, 32'h8000_0000, 32'h24, "srl");
        checkOutput("srl_const", out, 32'h0800_0000);
        applyStimulus(0, 1, 3'd2, 3'd5, 7'h20, 32'h8000_0000, 32'h24, "sra");
        checkOutput("sra_const", out, 32'hF800_0000);
        applyStimulus(0, 1, 3'd3, 3'd0, 7'h20, 32'h8000_0000, 32'h24, "addi");
        checkOutput("addi_const", out, 32'h8000_0024);
        applyStimulus(0, 1, 3'd3, 3'd5, 7'h20, 32'h8000_0000, 32'h24, "srai");

        applyStimulus(0, 1, 3'd2, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, "slt");
        checkOutput("slt_const", out, 32'd1);
        applyStimulus(0, 1, 3'd2, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, "sltu");
        checkOutput("sltu_const", out, 32'd0);
        applyStimulus(0, 1, 3'd1, 3'd5, 7'h00, 32'hFFFF_FFFF, 32'd1, "bge");
        checkOutput("bge_zero", {31'd0, is_zero}, 32'd1);
        applyStimulus(0, 1, 3'd1, 3'd7, 7'h00, 32'hFFFF_FFFF, 32'd1, "bgeu");
        checkOutput("bgeu_const", out, 32'd1);
        applyStimulus(0, 1, 3'd1, 3'd0, 7'h00, 32'h1234_5678, 32'h1234_5678, "beq");
        checkOutput("beq_zero", {31'd0, is_zero}, 32'd0);
        applyStimulus(0, 1, 3'd1, 3'd2, 7'h00, 32'h1, 32'h1, "branch_ill");

        applyStimulus(0, 1, 3'd2, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "and");
        checkOutput("and_const", out, 32'h00F0_00F0);
        applyStimulus(0, 1, 3'd2, 3'd6, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "or");
        checkOutput("or_const", out, 32'hFFF0_FFF0);
        applyStimulus(0, 1, 3'd2, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "xor");
        checkOutput("xor_const", out, 32'hFF00_FF00);
        applyStimulus(0, 1, 3'd4, 3'd0, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "lui");
        applyStimulus(0, 0, 3'd2, 3'd0, 7'h00, 32'd1, 32'd1, "hold");
        checkOutput("hold_const", out, 32'h0FF0_0FF0);
        applyStimulus(0, 1, 3'd6, 3'd0, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "illegal");
        checkOutput("illegal_zero", {31'd0, is_zero}, 32'd1);
        applyStimulus(0, 1, 3'd2, 3'd0, 7'h00, 32'd9, 32'd9, "stream");
        applyStimulus(1, 1, 3'd2, 3'd0, 7'h00, 32'd9, 32'd9, "mid_reset");

        for (int i = 0; i < 400; i++) begin
            r_r  = ($urandom_range(0, 29) == 0);
            r_v  = ($urandom_range(0, 3) != 0);
            r_op = 3'($urandom_range(0, 7));
            r_f3 = 3'($urandom);
            r_f7 = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
            r_a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            r_b  = ($urandom_range(0, 4) == 0) ? r_a :
                   ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            applyStimulus(r_r, r_v, r_op, r_f3, r_f7, r_a, r_b, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
